// File: rtl/lsu_mem_if_pkg.sv
// Shared types and encodings for the load/store unit memory interface.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Extender select encodings
   localparam logic [2:0] DS_WORD = 3'b000;
   localparam logic [2:0] DS_SB   = 3'b001;
   localparam logic [2:0] DS_SH   = 3'b010;
   localparam logic [2:0] DS_UB   = 3'b011;
   localparam logic [2:0] DS_UH   = 3'b100;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic [2:0] f3_to_datasrc(input logic [2:0] f3);
      case (f3)
         F3_B:    return DS_SB;
         F3_H:    return DS_SH;
         F3_BU:   return DS_UB;
         F3_HU:   return DS_UH;
         default: return DS_WORD;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_if_if.sv
// Word-oriented memory bus between the LSU (master) and memory (slave).
interface lsu_bus_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/lsu_mem_if_lane_steer.sv
// Decodes access size into byte strobes, lane-replicated store data, extender select and legality.
module lane_steer
   import lsu_pkg::*;
(
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata_lanes,
   output logic [2:0]  data_src,
   output logic        legal
);

   always_comb begin
      wstrb       = 4'b0000;
      wdata_lanes = wdata;
      data_src    = f3_to_datasrc(funct3);
      legal       = 1'b0;
      case (funct3)
         F3_B: begin
            legal       = 1'b1;
            wstrb       = 4'b0001 << addr_lo;
            wdata_lanes = {4{wdata[7:0]}};
         end
         F3_H: begin
            legal       = !addr_lo[0];
            wstrb       = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{wdata[15:0]}};
         end
         F3_W: begin
            legal = (addr_lo == 2'b00);
            wstrb = 4'b1111;
         end
         // Unsigned variants only exist for loads
         F3_BU:   legal = !is_store;
         F3_HU:   legal = !is_store && !addr_lo[0];
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_if.sv
// MEM-stage load/store unit: issues one bus access per op, stalls the core, aligns read data.
module lsu_mem_if
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] dataOut,
   output logic [2:0]  DataSrc,
   output logic        accErr,
   output logic        busErr,
   lsu_bus_if.master   bus
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg;
   logic [29:0]   waddr_reg;
   logic [1:0]    off_reg;
   logic          we_reg;
   logic [3:0]    wstrb_reg;
   logic [31:0]   wdata_reg;
   logic [2:0]    dsrc_reg;
   logic [31:0]   dout_reg;
   logic          berr_reg;

   logic          op, accept, acc_err, stall_c, ack_hit, timeout;
   logic [3:0]    steer_wstrb;
   logic [31:0]   steer_wdata;
   logic [2:0]    steer_dsrc;
   logic          steer_legal;

   assign op = MemRead | MemWrite;

   lane_steer u_lane_steer (
      .is_store    (MemWrite),
      .funct3      (funct3),
      .addr_lo     (addr[1:0]),
      .wdata       (wdata),
      .wstrb       (steer_wstrb),
      .wdata_lanes (steer_wdata),
      .data_src    (steer_dsrc),
      .legal       (steer_legal)
   );

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      acc_err    = 1'b0;
      stall_c    = 1'b0;
      ack_hit    = 1'b0;
      timeout    = 1'b0;
      unique case (state_reg)
         ST_IDLE: begin
            if (op) begin
               if (steer_legal) begin
                  accept     = 1'b1;
                  stall_c    = 1'b1;
                  state_next = ST_REQ;
               end else begin
                  acc_err = 1'b1;
               end
            end
         end
         ST_REQ: begin
            stall_c = 1'b1;
            if (bus.bus_ack) begin
               ack_hit    = 1'b1;
               state_next = ST_DONE;
            end else if (cnt_reg == CNT_LAST) begin
               timeout    = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         waddr_reg <= '0;
         off_reg   <= '0;
         we_reg    <= 1'b0;
         wstrb_reg <= '0;
         wdata_reg <= '0;
         dsrc_reg  <= DS_WORD;
         dout_reg  <= '0;
         berr_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         berr_reg  <= timeout;
         if (accept) begin
            cnt_reg   <= '0;
            waddr_reg <= addr[31:2];
            off_reg   <= addr[1:0];
            we_reg    <= MemWrite;
            // Loads never assert byte strobes
            wstrb_reg <= MemWrite ? steer_wstrb : 4'b0000;
            wdata_reg <= steer_wdata;
            dsrc_reg  <= steer_dsrc;
         end else if (state_reg == ST_REQ) begin
            cnt_reg <= cnt_reg + CW'(1);
         end
         if (ack_hit && !we_reg) begin
            dout_reg <= bus.bus_rdata >> {off_reg, 3'b000};
         end else if (timeout) begin
            dout_reg <= '0;
         end
      end
   end

   assign bus.bus_req   = (state_reg == ST_REQ);
   assign bus.bus_we    = we_reg;
   assign bus.bus_addr  = {waddr_reg, 2'b00};
   assign bus.bus_wstrb = wstrb_reg;
   assign bus.bus_wdata = wdata_reg;

   assign stall   = stall_c;
   assign accErr  = acc_err;
   assign busErr  = berr_reg;
   assign dataOut = dout_reg;
   assign DataSrc = dsrc_reg;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Scoreboard bench for lsu_mem_if: directed ops push expected bus/response records, a monitor pops and compares.
module tb_lsu_mem_if;

   localparam int K_DONE = 0;
   localparam int K_ACC  = 1;

   typedef struct {
      int          kind;
      logic [31:0] dout;
      logic [2:0]  dsrc;
      logic        berr;
      int          nstall;
      int          nreq;
   } rsp_t;

   typedef struct {
      logic        we;
      logic [31:0] a;
      logic [3:0]  strb;
      logic [31:0] wd;
   } bus_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        stall;
   logic [31:0] dataOut;
   logic [2:0]  DataSrc;
   logic        accErr;
   logic        busErr;

   lsu_bus_if bus ();

   rsp_t rsp_q[$];
   bus_t bus_q[$];
   int   checks = 0;
   int   errors = 0;
   logic mon_en = 1'b0;

   always #5 clk = ~clk;

   lsu_mem_if #(.TIMEOUT_CYCLES(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .funct3   (funct3),
      .addr     (addr),
      .wdata    (wdata),
      .stall    (stall),
      .dataOut  (dataOut),
      .DataSrc  (DataSrc),
      .accErr   (accErr),
      .busErr   (busErr),
      .bus      (bus)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end else begin
         $display("ok   %s = %h", name, got);
      end
   endtask

   task automatic exp_done(input logic [31:0] d, input logic [2:0] s, input logic be,
                           input int ns, input int nr);
      rsp_t r;
      r.kind = K_DONE; r.dout = d; r.dsrc = s; r.berr = be; r.nstall = ns; r.nreq = nr;
      rsp_q.push_back(r);
   endtask

   task automatic exp_acc();
      rsp_t r;
      r.kind = K_ACC; r.dout = '0; r.dsrc = '0; r.berr = 1'b0; r.nstall = 0; r.nreq = 0;
      rsp_q.push_back(r);
   endtask

   task automatic exp_bus(input logic we, input logic [31:0] a, input logic [3:0] st,
                          input logic [31:0] wd);
      bus_t b;
      b.we = we; b.a = a; b.strb = st; b.wd = wd;
      bus_q.push_back(b);
   endtask

   // Drive one op, acking in REQ cycle ack_at (0 = never), and release after stall drops
   task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rdat);
      bit finished = 0;
      @(posedge clk); #1;
      MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; wdata = wd;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (!stall) begin
            finished = 1;
            break;
         end
         @(posedge clk); #1;
         bus.bus_ack   = (k == ack_at);
         bus.bus_rdata = (k == ack_at) ? rdat : 32'hDEADBEEF;
      end
      if (!finished) begin
         checks++;
         errors++;
         $display("FAIL op_timeout stall still high after 40 cycles exp=0");
      end
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0; bus.bus_ack = 1'b0;
   endtask

   // Monitor: bus handshakes and per-op responses
   initial begin
      logic stall_prev = 1'b0;
      int   stall_cnt = 0;
      int   req_cnt = 0;
      rsp_t r;
      bus_t b;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (stall) stall_cnt++;
            if (bus.bus_req) req_cnt++;
            if (bus.bus_req && bus.bus_ack) begin
               checks++;
               if (bus_q.size() == 0) begin
                  errors++;
                  $display("FAIL bus_unexpected got we=%0b addr=%h exp=none", bus.bus_we, bus.bus_addr);
               end else begin
                  b = bus_q.pop_front();
                  if (bus.bus_we !== b.we || bus.bus_addr !== b.a || bus.bus_wstrb !== b.strb ||
                      (b.we && bus.bus_wdata !== b.wd)) begin
                     errors++;
                     $display("FAIL bus_txn got we=%0b addr=%h strb=%b wdata=%h exp we=%0b addr=%h strb=%b wdata=%h",
                              bus.bus_we, bus.bus_addr, bus.bus_wstrb, bus.bus_wdata, b.we, b.a, b.strb, b.wd);
                  end else begin
                     $display("ok   bus_txn we=%0b addr=%h strb=%b wdata=%h", b.we, b.a, b.strb, bus.bus_wdata);
                  end
               end
            end
            if (accErr) begin
               checks++;
               if (rsp_q.size() == 0) begin
                  errors++;
                  $display("FAIL acc_unexpected got accErr=1 exp=no response");
               end else begin
                  r = rsp_q.pop_front();
                  if (r.kind != K_ACC || stall !== 1'b0 || bus.bus_req !== 1'b0) begin
                     errors++;
                     $display("FAIL acc_err got accErr=1 stall=%0b bus_req=%0b exp kind=%0d stall=0 bus_req=0",
                              stall, bus.bus_req, r.kind);
                  end else begin
                     $display("ok   acc_err pulse, stall=0, no bus_req");
                  end
               end
               stall_cnt = 0;
               req_cnt = 0;
            end else if (stall_prev && !stall) begin
               checks++;
               if (rsp_q.size() == 0) begin
                  errors++;
                  $display("FAIL done_unexpected got dataOut=%h exp=no response", dataOut);
               end else begin
                  r = rsp_q.pop_front();
                  if (r.kind != K_DONE || dataOut !== r.dout || DataSrc !== r.dsrc ||
                      busErr !== r.berr || stall_cnt != r.nstall || req_cnt != r.nreq) begin
                     errors++;
                     $display("FAIL done got dout=%h src=%b berr=%0b stall=%0d req=%0d exp kind=%0d dout=%h src=%b berr=%0b stall=%0d req=%0d",
                              dataOut, DataSrc, busErr, stall_cnt, req_cnt,
                              r.kind, r.dout, r.dsrc, r.berr, r.nstall, r.nreq);
                  end else begin
                     $display("ok   done dout=%h src=%b berr=%0b stall=%0d req=%0d",
                              dataOut, DataSrc, busErr, stall_cnt, req_cnt);
                  end
               end
               stall_cnt = 0;
               req_cnt = 0;
            end else if (busErr) begin
               checks++;
               errors++;
               $display("FAIL busErr_stray got=1 exp=0");
            end
            stall_prev = stall;
         end
      end
   end

   initial begin
      bus.bus_ack   = 1'b0;
      bus.bus_rdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_stall",   {31'b0, stall},       32'h0);
      chk("rst_bus_req", {31'b0, bus.bus_req}, 32'h0);
      chk("rst_dataOut", dataOut,              32'h0);
      chk("rst_DataSrc", {29'b0, DataSrc},     32'h0);
      chk("rst_accErr",  {31'b0, accErr},      32'h0);
      chk("rst_busErr",  {31'b0, busErr},      32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_stall", {31'b0, stall}, 32'h0);
      mon_en = 1'b1;

      // LB 0x1003, ack in 2nd REQ cycle
      exp_bus(1'b0, 32'h0000_1000, 4'b0000, 32'h0);
      exp_done(32'h0000_00AA, 3'b001, 1'b0, 3, 2);
      do_op(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 2, 32'hAABB_CCDD);

      // SH 0x2002: upper half lanes, dataOut keeps previous load
      exp_bus(1'b1, 32'h0000_2000, 4'b1100, 32'h1234_1234);
      exp_done(32'h0000_00AA, 3'b010, 1'b0, 2, 1);
      do_op(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_1234, 1, 32'h0);

      // LW misaligned
      exp_acc();
      do_op(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 0, 32'h0);

      // LW with no ack: timeout after 4 REQ cycles
      exp_done(32'h0, 3'b000, 1'b1, 5, 4);
      do_op(1'b1, 1'b0, 3'b010, 32'h0000_3004, 32'h0, 0, 32'h0);

      // LW with same-cycle ack: minimum latency
      exp_bus(1'b0, 32'h0000_3008, 4'b0000, 32'h0);
      exp_done(32'h1122_3344, 3'b000, 1'b0, 2, 1);
      do_op(1'b1, 1'b0, 3'b010, 32'h0000_3008, 32'h0, 1, 32'h1122_3344);

      // LHU 0x300E, ack in 3rd REQ cycle
      exp_bus(1'b0, 32'h0000_300C, 4'b0000, 32'h0);
      exp_done(32'h0000_CAFE, 3'b100, 1'b0, 4, 3);
      do_op(1'b1, 1'b0, 3'b101, 32'h0000_300E, 32'h0, 3, 32'hCAFE_8001);

      // Illegal: LH odd address, store with funct3 100, load with funct3 011
      exp_acc();
      do_op(1'b1, 1'b0, 3'b001, 32'h0000_3011, 32'h0, 0, 32'h0);
      exp_acc();
      do_op(1'b0, 1'b1, 3'b100, 32'h0000_3010, 32'h55, 0, 32'h0);
      exp_acc();
      do_op(1'b1, 1'b0, 3'b011, 32'h0000_3010, 32'h0, 0, 32'h0);

      // Reset in 2nd REQ cycle of an LW, then a stray ack in IDLE
      exp_done(32'h0, 3'b000, 1'b0, 3, 2);
      @(posedge clk); #1;
      MemRead = 1'b1; funct3 = 3'b010; addr = 32'h0000_5000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1; MemRead = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      bus.bus_ack = 1'b1; bus.bus_rdata = 32'h5555_5555;
      repeat (2) @(posedge clk);
      #1 bus.bus_ack = 1'b0;

      // MemRead and MemWrite both set: store wins
      exp_bus(1'b1, 32'h0000_4000, 4'b0010, 32'hA5A5_A5A5);
      exp_done(32'h0, 3'b001, 1'b0, 3, 2);
      do_op(1'b1, 1'b1, 3'b000, 32'h0000_4001, 32'h0000_00A5, 2, 32'h0);

      // SW full word
      exp_bus(1'b1, 32'h0000_6000, 4'b1111, 32'hDEAD_BEEF);
      exp_done(32'h0, 3'b000, 1'b0, 2, 1);
      do_op(1'b0, 1'b1, 3'b010, 32'h0000_6000, 32'hDEAD_BEEF, 1, 32'h0);

      // LBU byte 1
      exp_bus(1'b0, 32'h0000_7000, 4'b0000, 32'h0);
      exp_done(32'h0000_0099, 3'b011, 1'b0, 2, 1);
      do_op(1'b1, 1'b0, 3'b100, 32'h0000_7001, 32'h0, 1, 32'h0000_9900);

      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rsp_q_left", rsp_q.size(), 32'h0);
      chk("bus_q_left", bus_q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_mem_if.md
LSU_MEM_IF -- requirements
Module: lsu_mem_if

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles to wait for bus_ack before abort.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 MemRead  in  1  load requested by MEM stage.
REQ-005 MemWrite  in  1  store requested by MEM stage.
REQ-006 funct3  in  3  RISC-V access size/sign field.
REQ-007 addr  in  32  byte address from ALU.
REQ-008 wdata  in  32  store data, rs2.
REQ-009 stall  out  1  freeze pipeline; inputs held stable by core while high.
REQ-010 dataOut  out  32  lane-aligned read word, byte 0 = addressed byte; feeds extender dataIn.
REQ-011 DataSrc  out  3  extender select: 000 word, 001 sb, 010 sh, 011 ub, 100 uh.
REQ-012 accErr  out  1  one-cycle pulse: misaligned or illegal funct3.
REQ-013 busErr  out  1  one-cycle pulse: bus timeout.
REQ-014 bus_req/bus_we  out  1/1  request valid / write.
REQ-015 bus_addr  out  32  {addr[31:2],2'b00}.
REQ-016 bus_wstrb/bus_wdata  out  4/32  byte strobes / lane-steered store data.
REQ-017 bus_ack/bus_rdata  in  1/32  completion, read word valid with ack.

Function
REQ-018 FSM states IDLE, REQ, DONE; op = MemRead|MemWrite; MemWrite wins if both set.
REQ-019 IDLE: legal op -> latch addr/strobes/wdata/we/DataSrc, go REQ; stall=1 combinationally that cycle.
REQ-020 Legality: funct3 in {000,001,010,100,101} for loads, {000,001,010} for stores; half needs addr[0]=0; word needs addr[1:0]=00.
REQ-021 IDLE illegal op: no bus_req, accErr=1 that cycle, stall=0, stay IDLE.
REQ-022 REQ: bus_req=1, outputs stable until bus_ack; stall=1; timeout counter increments each cycle.
REQ-023 REQ with bus_ack: capture dataOut = bus_rdata >> 8*addr[1:0] (loads; stores leave dataOut unchanged), go DONE.
REQ-024 REQ counter reaching TIMEOUT_CYCLES without ack: drop bus_req, busErr=1, dataOut=0, go DONE.
REQ-025 DONE: stall=0, dataOut/DataSrc valid exactly this cycle; no new op accepted; next state IDLE.
REQ-026 Min load latency: 3 cycles accept->DONE with same-cycle ack in first REQ cycle.
REQ-027 Store steering: sb {4{wdata[7:0]}}, wstrb 0001<<addr[1:0]; sh {2{wdata[15:0]}}, 0011 or 1100; sw wdata, 1111.
REQ-028 Loads: bus_wstrb=0000, bus_we=0.
REQ-029 bus_ack outside REQ ignored; counter cleared on entry to REQ.

Reset
REQ-030 reset (sync) anywhere, including mid-REQ: state IDLE, bus_req=0 from next edge, counter 0, dataOut 0, DataSrc 000, accErr/busErr 0, latched regs 0.
REQ-031 stall=0 after reset unless an op is presented in IDLE.

Structure
REQ-032 Package lsu_pkg holds FSM state enum, DataSrc encodings, funct3 constants.
REQ-033 One combinational sub-module lane_steer: funct3+addr[1:0]+wdata -> wstrb, wdata, DataSrc, legal.
REQ-034 Counter width $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-035 LB addr 0x1003, rdata 0xAABBCCDD, ack 2nd REQ cycle -> dataOut[7:0]=0xAA, DataSrc 001, stall 1 for 3 cycles.
REQ-036 SH addr 0x2002, wdata 0x1234 -> bus_wstrb 1100, bus_wdata 0x12341234, bus_addr 0x2000, bus_we 1.
REQ-037 LW addr 0x3001 -> no bus_req, accErr 1 one cycle, stall 0.
REQ-038 LW, TIMEOUT_CYCLES=4, no ack -> bus_req 4 cycles, busErr pulse, dataOut 0, stall released in DONE.
REQ-039 reset asserted in 2nd REQ cycle -> bus_req 0 next cycle, IDLE, later ack ignored.
REQ-040 MemRead=MemWrite=1 SB addr 0x4001 -> store, wstrb 0010.
